// File: rtl/parity_pkg.sv
// Shared types and the parity helper used by the push-side generator and the pop-side checker.
package parity_pkg;

  typedef enum logic {ODD = 1'b0, EVEN = 1'b1} parity_e;
  typedef enum logic {MSB = 1'b0, LSB = 1'b1} pbit_pos_e;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} skid_state_e;

  localparam int MAX_PAYLOAD_W = 64;

  // Zero-extending the payload up to MAX_PAYLOAD_W leaves its XOR reduction unchanged.
  function automatic logic parity_bit(input logic [MAX_PAYLOAD_W-1:0] payload,
                                      input logic parity);
    return (parity == EVEN) ? ^payload : ~^payload;
  endfunction

endpackage

// File: rtl/parity_encode.sv
// Combinational payload-to-encoded-word mapping: appends one parity bit at the LSB or MSB.
module parity_encode
  import parity_pkg::*;
#(
  parameter logic PARITY     = 1'b1,
  parameter logic P_BIT      = 1'b1,
  parameter int   DATA_WIDTH = 17
) (
  input  logic [DATA_WIDTH-2:0] payload,
  output logic [DATA_WIDTH-1:0] encoded
);

  logic p;

  always_comb begin
    p = parity_bit(MAX_PAYLOAD_W'(payload), PARITY);
    if (P_BIT == LSB) encoded = {payload, p};
    else              encoded = {p, payload};
  end

endmodule

// File: rtl/parity_gen.sv
// Push-side parity generator feeding a FIFO push port through a two-entry skid buffer.
// Optional feature: PARITY_ERR_INJECT_EN adds err_inject to corrupt parity of one accepted word.
module parity_gen
  import parity_pkg::*;
#(
  parameter logic PARITY     = 1'b1,
  parameter logic P_BIT      = 1'b1,
  parameter int   DATA_WIDTH = 17,
  parameter int   CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  output logic                  grant_out,
  input  logic [DATA_WIDTH-2:0] data_in,
  input  logic                  push_grant_in,
  output logic                  push_valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CNT_WIDTH-1:0]  word_count
`ifdef PARITY_ERR_INJECT_EN
  ,
  input  logic                  err_inject
`endif
);

  localparam int P_IDX = (P_BIT == LSB) ? 0 : DATA_WIDTH - 1;

  skid_state_e           state, state_nxt;
  logic [DATA_WIDTH-1:0] encoded, enc_word;
  logic [DATA_WIDTH-1:0] main_q, skid_q;
  logic                  accept, push;
  logic                  load_main, load_skid, move_skid;

  parity_encode #(
    .PARITY    (PARITY),
    .P_BIT     (P_BIT),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_encode (
    .payload(data_in),
    .encoded(encoded)
  );

`ifdef PARITY_ERR_INJECT_EN
  always_comb begin
    enc_word        = encoded;
    enc_word[P_IDX] = encoded[P_IDX] ^ err_inject;
  end
`else
  assign enc_word = encoded;
`endif

  assign accept = valid_in & grant_out;
  assign push   = push_valid_out & push_grant_in;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = ONE;
      ONE: begin
        if (accept && !push)      state_nxt = TWO;
        else if (push && !accept) state_nxt = EMPTY;
      end
      TWO:     if (push) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // grant_out is a function of registered state and rst only, never of push_grant_in.
  always_comb begin
    grant_out      = (state != TWO) & ~rst;
    push_valid_out = (state != EMPTY);
    load_main      = accept & ((state == EMPTY) | ((state == ONE) & push));
    load_skid      = accept & (state == ONE) & ~push;
    move_skid      = (state == TWO) & push;
  end

  always_ff @(posedge clk) begin
    if (rst)            main_q <= '0;
    else if (load_main) main_q <= enc_word;
    else if (move_skid) main_q <= skid_q;
  end

  always_ff @(posedge clk) begin
    if (load_skid) skid_q <= enc_word;
  end

  always_ff @(posedge clk) begin
    if (rst)       word_count <= '0;
    else if (push) word_count <= word_count + 1'b1;
  end

  assign data_out = main_q;

endmodule

// File: tb/tb_parity_gen.sv
// Directed bench for parity_gen: EVEN/LSB instance with a vector table, ODD/MSB instance with a small counter.
module tb_parity_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_valid = 1'b0, a_pg = 1'b0, a_grant, a_pv;
  logic [15:0] a_din = '0;
  logic [16:0] a_dout;
  logic [15:0] a_cnt;
  logic        a_err = 1'b0;

  logic        b_valid = 1'b0, b_pg = 1'b0, b_grant, b_pv;
  logic [15:0] b_din = '0;
  logic [16:0] b_dout;
  logic [3:0]  b_cnt;

  logic [15:0] sb_payload = '0;
  logic [16:0] sb_enc;

  int vectors = 0;
  int miscompares = 0;

  parity_gen #(.PARITY(1'b1), .P_BIT(1'b1), .DATA_WIDTH(17), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .valid_in(a_valid), .grant_out(a_grant), .data_in(a_din),
    .push_grant_in(a_pg), .push_valid_out(a_pv), .data_out(a_dout), .word_count(a_cnt)
`ifdef PARITY_ERR_INJECT_EN
    , .err_inject(a_err)
`endif
  );

  parity_gen #(.PARITY(1'b0), .P_BIT(1'b0), .DATA_WIDTH(17), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .valid_in(b_valid), .grant_out(b_grant), .data_in(b_din),
    .push_grant_in(b_pg), .push_valid_out(b_pv), .data_out(b_dout), .word_count(b_cnt)
`ifdef PARITY_ERR_INJECT_EN
    , .err_inject(1'b0)
`endif
  );

  parity_encode #(.PARITY(1'b1), .P_BIT(1'b1), .DATA_WIDTH(17)) u_ref (
    .payload(sb_payload), .encoded(sb_enc)
  );

  typedef struct {
    logic        v;
    logic [15:0] din;
    logic        pg;
    logic        e_pv;
    logic        chk_d;
    logic [16:0] e_d;
    logic        e_gr;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(logic v, logic [15:0] din, logic pg, logic e_pv, logic chk_d,
                              logic [16:0] e_d, logic e_gr, logic [15:0] e_cnt);
    vec_t r;
    r.v = v; r.din = din; r.pg = pg; r.e_pv = e_pv; r.chk_d = chk_d;
    r.e_d = e_d; r.e_gr = e_gr; r.e_cnt = e_cnt;
    return r;
  endfunction

  // Independent ODD/MSB reference for the second instance.
  function automatic logic [16:0] enc_om(logic [15:0] d);
    return {~^d, d};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = mk(1'b1, 16'h0003, 1'b1, 1'b0, 1'b0, 17'h00000, 1'b1, 16'd0);
    tbl[1]  = mk(1'b1, 16'h0001, 1'b1, 1'b1, 1'b1, 17'h00006, 1'b1, 16'd0);
    tbl[2]  = mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 17'h00003, 1'b1, 16'd1);
    tbl[3]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 17'h00000, 1'b1, 16'd2);
    tbl[4]  = mk(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0, 17'h00000, 1'b1, 16'd2);
    tbl[5]  = mk(1'b1, 16'h5555, 1'b0, 1'b1, 1'b1, 17'h15554, 1'b1, 16'd2);
    tbl[6]  = mk(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 17'h15554, 1'b0, 16'd2);
    tbl[7]  = mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 17'h15554, 1'b0, 16'd2);
    tbl[8]  = mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 17'h15554, 1'b0, 16'd2);
    tbl[9]  = mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 17'h0AAAA, 1'b1, 16'd3);
    tbl[10] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 17'h00000, 1'b1, 16'd4);

    // Initial reset: both instances quiet with grant low while rst is high.
    tick(); tick();
    chk("rst_a_grant", 32'(a_grant), 32'd0);
    chk("rst_a_pv",    32'(a_pv),    32'd0);
    chk("rst_a_dout",  32'(a_dout),  32'd0);
    chk("rst_a_cnt",   32'(a_cnt),   32'd0);
    chk("rst_b_grant", 32'(b_grant), 32'd0);
    chk("rst_b_pv",    32'(b_pv),    32'd0);
    rst = 1'b0;

    // ODD/MSB instance: encoding and 4-bit counter wrap.
    b_pg = 1'b1; b_valid = 1'b1; b_din = 16'h0001;
    tick();
    chk("b_word0", 32'(b_dout), 32'h00001);
    chk("b_pv0",   32'(b_pv),   32'd1);
    b_din = 16'h0000;
    tick();
    chk("b_word1", 32'(b_dout), 32'h10000);
    chk("b_cnt1",  32'(b_cnt),  32'd1);
    for (int j = 0; j < 14; j++) begin
      b_din = 16'(j * 16'h0123);
      tick();
      chk("b_stream_d", 32'(b_dout), 32'(enc_om(16'(j * 16'h0123))));
      chk("b_stream_cnt", 32'(b_cnt), 32'(2 + j));
    end
    b_valid = 1'b0;
    tick();
    chk("b_cnt_wrap", 32'(b_cnt), 32'd0);
    chk("b_pv_empty", 32'(b_pv),  32'd0);
    b_pg = 1'b0;

    // EVEN/LSB table: pass-through, then two-deep hold and ordered drain.
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("tbl%0d_pv", i),  32'(a_pv),    32'(tbl[i].e_pv));
      chk($sformatf("tbl%0d_gr", i),  32'(a_grant), 32'(tbl[i].e_gr));
      chk($sformatf("tbl%0d_cnt", i), 32'(a_cnt),   32'(tbl[i].e_cnt));
      if (tbl[i].chk_d) chk($sformatf("tbl%0d_d", i), 32'(a_dout), 32'(tbl[i].e_d));
      a_valid = tbl[i].v; a_din = tbl[i].din; a_pg = tbl[i].pg;
      tick();
    end

    // Reset, then 8 back-to-back words at full throughput.
    rst = 1'b1; a_valid = 1'b0;
    tick();
    chk("rst2_cnt", 32'(a_cnt), 32'd0);
    rst = 1'b0; a_pg = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_valid = (i < 8);
      a_din = 16'hC000 + 16'(i * 16'h0357);
      sb_payload = a_din;
      #1;
      begin
        logic [16:0] exp_w;
        exp_w = sb_enc;
        tick();
        chk("b2b_pv",  32'(a_pv),    32'(i < 8));
        chk("b2b_gr",  32'(a_grant), 32'd1);
        chk("b2b_cnt", 32'(a_cnt),   32'((i <= 8) ? i : 8));
        if (i < 8) chk("b2b_d", 32'(a_dout), 32'(exp_w));
      end
    end
    chk("b2b_total", 32'(a_cnt), 32'd8);

    // Reset while two words are buffered: both are discarded.
    a_pg = 1'b0; a_valid = 1'b1; a_din = 16'h1234;
    tick();
    a_din = 16'h4321;
    tick();
    a_valid = 1'b0;
    chk("two_gr", 32'(a_grant), 32'd0);
    chk("two_pv", 32'(a_pv),    32'd1);
    rst = 1'b1;
    #1;
    chk("two_rst_gr", 32'(a_grant), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("two_rst_pv",   32'(a_pv),    32'd0);
    chk("two_rst_dout", 32'(a_dout),  32'd0);
    chk("two_rst_cnt",  32'(a_cnt),   32'd0);
    chk("two_rst_gr1",  32'(a_grant), 32'd1);
    a_pg = 1'b1;
    tick();
    chk("two_lost_pv",  32'(a_pv),  32'd0);
    chk("two_lost_cnt", 32'(a_cnt), 32'd0);

`ifdef PARITY_ERR_INJECT_EN
    a_valid = 1'b1; a_din = 16'h0003; a_err = 1'b1;
    tick();
    chk("inj_bad", 32'(a_dout), 32'h00007);
    a_err = 1'b0;
    tick();
    chk("inj_clean", 32'(a_dout), 32'h00006);
    a_valid = 1'b0;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/parity_gen.md
# parity_gen

Push-side parity generator for the parity-protected FIFO path. It accepts raw payload words over a valid/grant handshake and appends one parity bit. It then presents the encoded word to the FIFO push port through a two-entry skid buffer, giving full throughput without a combinational path from downstream grant to upstream grant. It is the generator paired with the pop-side parity checker: both must use identical PARITY and P_BIT settings.

## Interface
- PARITY, 1'b1: parity sense; 1'b1 EVEN (total ones in encoded word even), 1'b0 ODD
- P_BIT, 1'b1: parity bit position; 1'b1 LSB, 1'b0 MSB
- DATA_WIDTH, 17: encoded word width including parity; payload is DATA_WIDTH-1
- CNT_WIDTH, 16: width of pushed-word counter
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  upstream payload valid
- grant_out  out  1  block can accept a payload this cycle
- data_in  in  DATA_WIDTH-1  payload
- push_grant_in  in  1  FIFO can accept a push
- push_valid_out  out  1  encoded word valid
- data_out  out  DATA_WIDTH  encoded word
- word_count  out  CNT_WIDTH  count of completed pushes
- err_inject  in  1  only with PARITY_ERR_INJECT_EN; corrupt parity of word accepted this cycle

## Operation
- Accept = valid_in & grant_out; push = push_valid_out & push_grant_in.
- Parity bit p = ^data_in (EVEN) or ~^data_in (ODD); encoded = {data_in, p} when P_BIT=1, {p, data_in} when P_BIT=0.
- Storage: main register (drives data_out) and skid register; state EMPTY, ONE, TWO.
- EMPTY: accept -> ONE (encoded into main).
- ONE: accept & push -> ONE (main reloaded); accept & ~push -> TWO (encoded into skid); push & ~accept -> EMPTY; neither -> ONE.
- TWO: grant_out=0, no accept; push -> ONE (skid moves to main); else hold.
- push_valid_out = (state != EMPTY); grant_out = (state != TWO) & ~rst.
- Words leave in acceptance order; none dropped or duplicated.
- word_count increments by 1 on each push, wraps 2^CNT_WIDTH-1 -> 0.
- Reset: state EMPTY, push_valid_out 0, data_out 0, word_count 0, grant_out 0 while rst high; buffered words discarded, including reset mid-transfer or in TWO.

## Timing
- Latency: accepted word appears on data_out/push_valid_out the next cycle.
- Throughput: one word per cycle while push_grant_in stays high.
- grant_out depends only on registered state (and rst): no path from push_grant_in or valid_in.
- data_out and push_valid_out stable while push_valid_out & ~push_grant_in.
- grant_out returns to 1 the cycle after a push out of TWO.
- First accept possible in the first cycle after rst deasserts.

## Configuration
- PARITY_ERR_INJECT_EN defined: err_inject port present; when err_inject is high on an accept, the parity bit of that word only is inverted. Subsequent words are unaffected.
- Undefined: no err_inject port, parity always correct; identical timing otherwise.

## Structure
- Shared package parity_pkg: parity_e (ODD=1'b0, EVEN=1'b1), pbit_pos_e (MSB=1'b0, LSB=1'b1), skid_state_e (EMPTY, ONE, TWO), function parity_bit(payload, parity).
- The checker imports the same package.
- Sub-module parity_encode: combinational payload-to-encoded-word mapping, parameterized by PARITY, P_BIT, DATA_WIDTH. It is reused by the testbench scoreboard.

## Test plan
- EVEN/LSB, push_grant_in=1: data_in 16'h0003 -> next cycle data_out 17'h00006; then 16'h0001 -> 17'h00003.
- ODD/MSB: data_in 16'h0001 -> data_out 17'h00001; data_in 16'h0000 -> 17'h10000.
- EVEN/LSB, push_grant_in=0: accept 16'hAAAA, 16'h5555 -> grant_out 0 after second accept, data_out held at 17'h15554. Raise push_grant_in -> 17'h15554 then 17'h0AAAA in order, grant_out 1 the cycle after first push.
- 8 back-to-back words, push_grant_in=1 -> push_valid_out high 8 consecutive cycles, word_count=8; preload count 16'hFFFF plus one push -> 0.
- rst pulsed one cycle in TWO -> push_valid_out 0, data_out 0, word_count 0, both words lost, grant_out 1 next cycle.
- PARITY_ERR_INJECT_EN, EVEN/LSB: err_inject=1 with 16'h0003 -> 17'h00007; following 16'h0003 without inject -> 17'h00006.
